id_ex_skid_buffer: RTL

- Parametrised elastic ID/EX pipeline buffer for the MIPS pipeline.
- Carries pc, operand A/B, offset, jump address, destination register, opcode and control signals from decode to execute.
- Replaces the always-load stage register with a valid/ready handshake and a 2-entry skid buffer, so execute can stall without a combinational ready path back into decode.
- Adds flush (bubble insertion) for branch/jump squash and exposes occupancy.

---
 rtl/id_ex_skid_buffer.sv | 112 +++++++++++
 1 files changed

// File: rtl/id_ex_skid_buffer.sv
// ID/EX elastic pipeline buffer: a main register that drives execute directly,
// plus one skid register that absorbs the bundle decode sent in the cycle
// execute stalled. in_ready depends only on state flops, so there is no
// combinational path from out_ready back to in_ready.
module id_ex_skid_buffer #(
  parameter int XLEN   = 32,
  parameter int DEST_W = 5,
  parameter int OP_W   = 6,
  parameter int SIG_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   valA_in,
  input  logic [XLEN-1:0]   valB_in,
  input  logic [XLEN-1:0]   offset_in,
  input  logic [XLEN-1:0]   jump_addr_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [OP_W-1:0]   op_in,
  input  logic [SIG_W-1:0]  signals_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   valA_out,
  output logic [XLEN-1:0]   valB_out,
  output logic [XLEN-1:0]   offset_out,
  output logic [XLEN-1:0]   jump_addr_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [OP_W-1:0]   op_out,
  output logic [SIG_W-1:0]  signals_out,
  output logic [1:0]        occupancy
);

  localparam int BUNDLE_W = 5 * XLEN + DEST_W + OP_W + SIG_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state;
  logic [BUNDLE_W-1:0] main_q;
  logic [BUNDLE_W-1:0] skid_q;
  logic [BUNDLE_W-1:0] in_bundle;
  logic                accept;
  logic                consume;

  // All eight fields travel together as one packed bundle.
  assign in_bundle = {pc_in, valA_in, valB_in, offset_in, jump_addr_in,
                      dest_in, op_in, signals_in};

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // The main register feeds execute directly; it is zero whenever no bundle is held.
  assign {pc_out, valA_out, valB_out, offset_out, jump_addr_out,
          dest_out, op_out, signals_out} = main_q;

  // Occupancy FSM and data movement; flush outranks every handshake and
  // registers load only on accept so undriven data inputs never reach execute.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_bundle;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_q <= in_bundle;
          end else if (accept) begin
            skid_q <= in_bundle;
            state  <= TWO;
          end else if (consume) begin
            main_q <= '0;
            state  <= EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            main_q <= skid_q;
            skid_q <= '0;
            state  <= ONE;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end
      endcase
    end
  end

endmodule
